iter_mult: RTL and testbench

//  Parametrised sequential successor to the combinational FastMult.

---
 rtl/iter_mult.sv | 119 +++++++++++
 tb/tb_iter_mult.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/iter_mult.sv
// Iterative shift-add multiplier with valid/ready handshakes and per-op signed mode.
// Retires STEP multiplier bits per BUSY cycle; the product is presented in DONE until accepted.
module iter_mult #(
  parameter int WIDTH = 4,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_lhs,
  input  logic [WIDTH-1:0]   in_rhs,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_data
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;

  logic [WIDTH-1:0]     lhs_mag, rhs_mag;
  logic [2*WIDTH-1:0]   partial, acc_sum;

  always_comb begin
    // Negating the most-negative value wraps to 2^(WIDTH-1), which is the correct magnitude.
    lhs_mag = (in_signed && in_lhs[WIDTH-1]) ? -in_lhs : in_lhs;
    rhs_mag = (in_signed && in_rhs[WIDTH-1]) ? -in_rhs : in_rhs;
    partial = mcand_q * {{(2*WIDTH-STEP){1'b0}}, mplier_q[STEP-1:0]};
    acc_sum = acc_q + partial;

    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d    = {{WIDTH{1'b0}}, lhs_mag};
          mplier_d   = rhs_mag;
          acc_d      = '0;
          cnt_d      = CW'(N);
          neg_d      = in_signed & (in_lhs[WIDTH-1] ^ in_rhs[WIDTH-1]);
          state_d    = BUSY;
          in_ready_d = 1'b0;
        end
      end
      BUSY: begin
        // The multiplicand is pre-shifted so each partial lands at its own weight.
        acc_d    = acc_sum;
        mcand_d  = mcand_q << STEP;
        mplier_d = mplier_q >> STEP;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_data_d  = neg_q ? -acc_sum : acc_sum;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
endmodule

// File: tb/tb_iter_mult.sv
// Directed bench for iter_mult: a W=4/S=1 instance and a W=8/S=2 instance on one clock,
// with expected products queued at acceptance and compared when the product is handed off.
module tb_iter_mult;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       a_in_valid, a_in_ready, a_sgn, a_out_valid, a_out_ready;
  logic [3:0] a_lhs, a_rhs;
  logic [7:0] a_out_data;

  logic       b_in_valid, b_in_ready, b_sgn, b_out_valid, b_out_ready;
  logic [7:0] b_lhs, b_rhs;
  logic [15:0] b_out_data;

  iter_mult #(.WIDTH(4), .STEP(1)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_lhs(a_lhs), .in_rhs(a_rhs),
    .in_signed(a_sgn), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
  );

  iter_mult #(.WIDTH(8), .STEP(2)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_lhs(b_lhs), .in_rhs(b_rhs),
    .in_signed(b_sgn), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0]  q4[$];
  logic [15:0] q8[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input logic s, input logic [7:0] exp, input int hold);
    int e;
    @(negedge clk);
    chk({tag, " ready_idle"}, 32'(a_in_ready), 1);
    a_in_valid = 1'b1; a_lhs = a; a_rhs = b; a_sgn = s;
    q4.push_back(exp);
    @(negedge clk);
    // Scramble inputs after acceptance; the op in flight must not see them.
    a_in_valid = 1'b0; a_sgn = ~s; a_lhs = ~a; a_rhs = ~b;
    e = 0;
    while (a_out_valid !== 1'b1 && e < 20) begin
      chk({tag, " ready_busy"}, 32'(a_in_ready), 0);
      @(negedge clk);
      e++;
    end
    chk({tag, " latency"}, 32'(e), 4);
    repeat (hold) begin
      a_in_valid = 1'b1;
      chk({tag, " hold_valid"}, 32'(a_out_valid), 1);
      chk({tag, " hold_data"}, 32'(a_out_data), 32'(exp));
      chk({tag, " hold_ready"}, 32'(a_in_ready), 0);
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    chk({tag, " data"}, 32'(a_out_data), 32'(q4.pop_front()));
    @(negedge clk);
    a_out_ready = 1'b0;
    chk({tag, " valid_drop"}, 32'(a_out_valid), 0);
    chk({tag, " ready_back"}, 32'(a_in_ready), 1);
    chk({tag, " data_kept"}, 32'(a_out_data), 32'(exp));
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic s, input logic [15:0] exp);
    int e;
    @(negedge clk);
    chk({tag, " ready_idle"}, 32'(b_in_ready), 1);
    b_in_valid = 1'b1; b_lhs = a; b_rhs = b; b_sgn = s;
    q8.push_back(exp);
    @(negedge clk);
    b_in_valid = 1'b0; b_sgn = ~s; b_lhs = ~a; b_rhs = ~b;
    e = 0;
    while (b_out_valid !== 1'b1 && e < 20) begin
      @(negedge clk);
      e++;
    end
    chk({tag, " latency"}, 32'(e), 4);
    b_out_ready = 1'b1;
    chk({tag, " data"}, 32'(b_out_data), 32'(q8.pop_front()));
    @(negedge clk);
    b_out_ready = 1'b0;
    chk({tag, " valid_drop"}, 32'(b_out_valid), 0);
    chk({tag, " ready_back"}, 32'(b_in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    a_in_valid = 1'b0; a_lhs = '0; a_rhs = '0; a_sgn = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_lhs = '0; b_rhs = '0; b_sgn = 1'b0; b_out_ready = 1'b0;
    #1;
    chk("rst a_out_valid", 32'(a_out_valid), 0);
    chk("rst a_out_data", 32'(a_out_data), 0);
    chk("rst b_out_valid", 32'(b_out_valid), 0);
    chk("rst b_out_data", 32'(b_out_data), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst a_in_ready", 32'(a_in_ready), 1);
    chk("rst b_in_ready", 32'(b_in_ready), 1);

    op4("u2x3", 4'd2, 4'd3, 1'b0, 8'h06, 0);
    op4("u15x15", 4'd15, 4'd15, 1'b0, 8'hE1, 0);
    op4("u0x9", 4'd0, 4'd9, 1'b0, 8'h00, 0);
    op4("s-8x-8", 4'h8, 4'h8, 1'b1, 8'h40, 0);
    op4("s-3x5_bp", 4'hD, 4'h5, 1'b1, 8'hF1, 5);
    op4("s-8x7", 4'h8, 4'h7, 1'b1, 8'hC8, 0);
    op4("s7x-1", 4'h7, 4'hF, 1'b1, 8'hF9, 0);

    op8("u200x100", 8'd200, 8'd100, 1'b0, 16'h4E20);
    op8("s80x7f", 8'h80, 8'h7F, 1'b1, 16'hC080);
    op8("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01);

    // Reset in the middle of an op: nothing of it may ever surface.
    @(negedge clk);
    a_in_valid = 1'b1; a_lhs = 4'd5; a_rhs = 4'd6; a_sgn = 1'b0;
    q4.push_back(8'h1E);
    @(negedge clk);
    a_in_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    q4.delete();
    #1;
    chk("midrst out_valid", 32'(a_out_valid), 0);
    chk("midrst out_data", 32'(a_out_data), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst in_ready", 32'(a_in_ready), 1);
    for (int i = 0; i < 8; i++) begin
      chk("midrst no_stale", 32'(a_out_valid), 0);
      @(negedge clk);
    end
    chk("midrst data_clear", 32'(a_out_data), 0);
    op4("post_rst 3x3", 4'd3, 4'd3, 1'b0, 8'h09, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
